// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider controller.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = DIV_WIDTH;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        SIGN,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
interface div_if #(
    parameter int WIDTH = div_pkg::DIV_WIDTH
);
    import div_pkg::*;

    // Handshake: start is a request pulse, honoured only when busy=0. done pulses
    // for exactly one cycle when lo_out/hi_out/div_by_zero become valid; those
    // outputs then hold until the next accepted start or clear.
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] lo_out;
    logic [WIDTH-1:0] hi_out;
    div_state_t       state_dbg;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, div_by_zero, lo_out, hi_out, state_dbg
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, div_by_zero, lo_out, hi_out, state_dbg
    );

endinterface

// File: rtl/div_step.sv
// One non-restoring division step on the {A,Q} pair against divisor magnitude M.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] a_shift;

    assign a_shift = {a_in[WIDTH-1:0], q_in[WIDTH-1]};

    // The sign of the old accumulator picks subtract or add-back.
    always_comb begin
        a_out = '0;
        q_out = '0;
        if (a_in[WIDTH]) begin
            a_out = a_shift + {1'b0, m_in};
        end else begin
            a_out = a_shift - {1'b0, m_in};
        end
        q_out = {q_in[WIDTH-2:0], ~a_out[WIDTH]};
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for the 32-step non-restoring divider: operand latch, iteration,
// remainder correction, signed fix-up and divide-by-zero handling.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic  clk,
    input logic  clear,
    div_if.slave bus
);

    localparam int CW = $clog2(DIV_ITERS);
    typedef logic [CW-1:0] cnt_t;

    div_state_t       state;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] mag_m;
    cnt_t             count;

    logic             signed_r;
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;

    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;

    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] quo_step;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_in  (acc),
        .q_in  (quo),
        .m_in  (mag_m),
        .a_out (acc_step),
        .q_out (quo_step)
    );

    // Magnitudes are WIDTH-bit unsigned, so negating the most negative value is exact.
    assign dvd_neg   = signed_r & dividend_r[WIDTH-1];
    assign dvs_neg   = signed_r & divisor_r[WIDTH-1];
    assign dvd_mag   = dvd_neg ? (~dividend_r + 1'b1) : dividend_r;
    assign dvs_mag   = dvs_neg ? (~divisor_r + 1'b1) : divisor_r;
    assign quo_final = (dvd_neg ^ dvs_neg) ? (~quo + 1'b1) : quo;
    assign rem_final = dvd_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= IDLE;
            acc        <= '0;
            quo        <= '0;
            mag_m      <= '0;
            count      <= '0;
            signed_r   <= 1'b0;
            dividend_r <= '0;
            divisor_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dbz_r      <= 1'b0;
            lo_r       <= '0;
            hi_r       <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        signed_r   <= bus.signed_op;
                        dividend_r <= bus.dividend;
                        divisor_r  <= bus.divisor;
                        dbz_r      <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= PREP;
                    end
                end
                PREP: begin
                    if (divisor_r == '0) begin
                        lo_r   <= WIDTH'(DBZ_QUOTIENT);
                        hi_r   <= dividend_r;
                        dbz_r  <= 1'b1;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        mag_m <= dvs_mag;
                        quo   <= dvd_mag;
                        acc   <= '0;
                        count <= '0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    acc   <= acc_step;
                    quo   <= quo_step;
                    count <= count + 1'b1;
                    if (count == cnt_t'(DIV_ITERS - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // A negative final accumulator still owes one add-back of M.
                    if (acc[WIDTH]) begin
                        acc <= acc + {1'b0, mag_m};
                    end
                    state <= SIGN;
                end
                SIGN: begin
                    lo_r   <= quo_final;
                    hi_r   <= rem_final;
                    done_r <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.lo_out      = lo_r;
    assign bus.hi_out      = hi_r;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: scoreboard queues filled by the driver, drained by a done monitor.
module tb_div_ctrl;
    import div_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic clear;

    always #5 clk = ~clk;

    div_if #(.WIDTH(W)) bus ();

    div_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] exp_lo_q[$];
    logic [W-1:0] exp_hi_q[$];
    logic         exp_dbz_q[$];
    int           exp_cyc_q[$];

    int n_vec      = 0;
    int n_bad      = 0;
    int n_done     = 0;
    int exp_n_done = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            n_done++;
            if (exp_lo_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
                check("lo_out", bus.lo_out, exp_lo_q.pop_front());
                check("hi_out", bus.hi_out, exp_hi_q.pop_front());
                check("div_by_zero", W'(bus.div_by_zero), W'(exp_dbz_q.pop_front()));
                check("done_cycle", W'(cyc), W'(exp_cyc_q.pop_front()));
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] lo, input logic [W-1:0] hi, input logic dbz, input int lat);
        exp_lo_q.push_back(lo);
        exp_hi_q.push_back(hi);
        exp_dbz_q.push_back(dbz);
        exp_cyc_q.push_back(cyc + 1 + lat);
        exp_n_done++;
    endtask

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start     = 1'b1;
        bus.signed_op = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.signed_op = ~s;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] lo, input logic [W-1:0] hi, input logic dbz,
                           input int lat, input int busy_len);
        int n;
        push_exp(lo, hi, dbz, lat);
        issue(s, a, b);
        wait_idle(n);
        check("busy_cycles", W'(n), W'(busy_len));
        check("scoreboard_drained", W'(exp_lo_q.size()), '0);
    endtask

    initial begin
        int n;
        clear         = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        clear = 1'b0;

        check("reset_busy", W'(bus.busy), '0);
        check("reset_done", W'(bus.done), '0);
        check("reset_dbz", W'(bus.div_by_zero), '0);
        check("reset_lo", bus.lo_out, '0);
        check("reset_hi", bus.hi_out, '0);
        check("reset_state", W'(bus.state_dbg), W'(IDLE));

        run_div(1'b0, 32'd50, 32'd7, 32'd7, 32'd1, 1'b0, 35, 36);
        run_div(1'b1, -32'sd50, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 35, 36);
        run_div(1'b1, 32'd50, -32'sd7, 32'hFFFF_FFF9, 32'd1, 1'b0, 35, 36);
        run_div(1'b1, -32'sd50, -32'sd7, 32'd7, 32'hFFFF_FFFF, 1'b0, 35, 36);
        run_div(1'b0, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b1, 1, 2);

        repeat (3) @(negedge clk);
        check("dbz_held", W'(bus.div_by_zero), 32'd1);
        check("dbz_lo_held", bus.lo_out, 32'hFFFF_FFFF);

        run_div(1'b0, 32'd11, 32'd3, 32'd3, 32'd2, 1'b0, 35, 36);
        check("dbz_cleared", W'(bus.div_by_zero), '0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 35, 36);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 35, 36);
        run_div(1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 35, 36);
        run_div(1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 35, 36);
        run_div(1'b0, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0, 35, 36);
        run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1, 2);

        // A second start mid-iteration must be dropped.
        push_exp(32'd7, 32'd1, 1'b0, 35);
        issue(1'b0, 32'd50, 32'd7);
        repeat (11) @(negedge clk);
        issue(1'b0, 32'd100, 32'd6);
        wait_idle(n);
        repeat (40) @(negedge clk);
        check("ignored_start_busy", W'(bus.busy), '0);
        check("ignored_start_lo", bus.lo_out, 32'd7);
        check("ignored_start_done_count", W'(n_done), W'(exp_n_done));

        // clear mid-iteration wins over a simultaneous start.
        issue(1'b0, 32'd50, 32'd7);
        repeat (10) @(negedge clk);
        clear         = 1'b1;
        bus.start     = 1'b1;
        bus.dividend  = 32'd9;
        bus.divisor   = 32'd3;
        @(negedge clk);
        clear     = 1'b0;
        bus.start = 1'b0;
        check("clear_busy", W'(bus.busy), '0);
        check("clear_lo", bus.lo_out, '0);
        check("clear_hi", bus.hi_out, '0);
        check("clear_done", W'(bus.done), '0);
        check("clear_state", W'(bus.state_dbg), W'(IDLE));
        repeat (40) @(negedge clk);
        check("clear_start_ignored", W'(bus.busy), '0);
        check("clear_no_done", W'(n_done), W'(exp_n_done));
        check("final_queue_empty", W'(exp_lo_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
